// File: rtl/cmem_pkg.sv
// Shared type codes, FSM encoding and line/word geometry for the cache memory responder.
package cmem_pkg;

    localparam logic [2:0] T_BYTE = 3'b000;
    localparam logic [2:0] T_HALF = 3'b001;
    localparam logic [2:0] T_WORD = 3'b010;
    localparam logic [2:0] T_LINE = 3'b100;

    localparam int WORD_BITS  = 32;
    localparam int LINE_WORDS = 4;
    localparam int LINE_BYTES = 16;
    localparam int LINE_BITS  = WORD_BITS * LINE_WORDS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_BURST = 2'd2
    } state_t;

    // Every code other than T_LINE moves a single aligned word.
    function automatic logic is_line(input logic [2:0] t);
        return t == T_LINE;
    endfunction

endpackage

// File: rtl/cmem_bank.sv
// One 32-bit word column of the line store: byte-strobed synchronous write, combinational read.
module cmem_bank
    import cmem_pkg::*;
#(
    parameter int ADDR_BITS = 12
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_BITS-1:0]  i_widx,
    input  logic [3:0]            i_wstrb,
    input  logic [WORD_BITS-1:0]  i_wdata,
    input  logic [ADDR_BITS-1:0]  i_ridx,
    output logic [WORD_BITS-1:0]  o_rdata
);

    // Contents are intentionally not reset.
    logic [WORD_BITS-1:0] r_mem [0:(1<<ADDR_BITS)-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_wstrb[b]) r_mem[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/cache_mem_responder.sv
// Cache-facing memory model: fixed-latency word/line reads, single-cycle writes.
// Define CMEM_BEAT_GAP_EN to insert an idle cycle between line-read beats.
module cache_mem_responder
    import cmem_pkg::*;
#(
    parameter int ADDR_BITS = 12,
    parameter int RD_LAT    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rd_req,
    input  logic [2:0]           rd_type,
    input  logic [31:0]          rd_addr,
    output logic                 rd_rdy,
    output logic                 ret_valid,
    output logic                 ret_last,
    output logic [31:0]          ret_data,
    input  logic                 wr_req,
    input  logic [2:0]           wr_type,
    input  logic [31:0]          wr_addr,
    input  logic [3:0]           wr_wstrb,
    input  logic [LINE_BITS-1:0] wr_data,
    output logic                 wr_rdy
);

`ifdef CMEM_BEAT_GAP_EN
    localparam logic GAP_EN = 1'b1;
`else
    localparam logic GAP_EN = 1'b0;
`endif

    state_t               r_state, w_state_nx;
    logic [3:0]           r_cnt, w_cnt_nx;
    logic [1:0]           r_beat, w_beat_nx;
    logic                 r_gap, w_gap_nx;
    logic                 r_line, w_line_nx;
    logic [ADDR_BITS+1:0] r_addr, w_addr_nx;   // word index of the pending read
    logic                 w_ret_valid, w_ret_last;
    logic                 w_idle, w_wr_fire, w_wr_line;
    logic [1:0]           w_word;
    logic [LINE_WORDS-1:0][WORD_BITS-1:0] w_bank_rdata;
    logic                 w_unused;

    assign w_unused = ^{rd_addr[1:0], rd_addr[31:ADDR_BITS+4], wr_addr[1:0], wr_addr[31:ADDR_BITS+4]};

    assign w_idle    = (r_state == S_IDLE) && !reset;
    assign rd_rdy    = w_idle;
    assign wr_rdy    = w_idle;
    assign w_wr_fire = wr_req && w_idle;
    assign w_wr_line = is_line(wr_type);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_beat  <= '0;
            r_gap   <= 1'b0;
            r_line  <= 1'b0;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_beat  <= w_beat_nx;
            r_gap   <= w_gap_nx;
            r_line  <= w_line_nx;
            r_addr  <= w_addr_nx;
        end
    end

    // Counter is loaded with RD_LAT-1 so the first beat lands RD_LAT edges after accept.
    always_comb begin
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_beat_nx   = r_beat;
        w_gap_nx    = r_gap;
        w_line_nx   = r_line;
        w_addr_nx   = r_addr;
        w_ret_valid = 1'b0;
        w_ret_last  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (rd_req) begin
                    w_state_nx = S_WAIT;
                    w_cnt_nx   = 4'(RD_LAT - 1);
                    w_addr_nx  = rd_addr[ADDR_BITS+3:2];
                    w_line_nx  = is_line(rd_type);
                    w_beat_nx  = '0;
                    w_gap_nx   = 1'b0;
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) w_state_nx = S_BURST;
                else             w_cnt_nx   = r_cnt - 4'd1;
            end
            S_BURST: begin
                if (GAP_EN && r_gap) begin
                    w_gap_nx = 1'b0;
                end else begin
                    w_ret_valid = 1'b1;
                    if (!r_line || r_beat == 2'd3) begin
                        w_ret_last = 1'b1;
                        w_state_nx = S_IDLE;
                    end else begin
                        w_beat_nx = r_beat + 2'd1;
                        w_gap_nx  = GAP_EN;
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Banks are read live, so the beat reflects memory at beat time.
    assign w_word    = r_line ? r_beat : r_addr[1:0];
    assign ret_valid = w_ret_valid && !reset;
    assign ret_last  = w_ret_last && !reset;
    assign ret_data  = ret_valid ? w_bank_rdata[w_word] : '0;

    for (genvar g = 0; g < LINE_WORDS; g++) begin : g_bank
        logic                 w_we;
        logic [3:0]           w_strb;
        logic [WORD_BITS-1:0] w_wdata;

        assign w_we    = w_wr_fire && (w_wr_line || wr_addr[3:2] == 2'(g));
        assign w_strb  = w_wr_line ? 4'hF : wr_wstrb;
        assign w_wdata = w_wr_line ? wr_data[WORD_BITS*g +: WORD_BITS] : wr_data[WORD_BITS-1:0];

        cmem_bank #(.ADDR_BITS(ADDR_BITS)) u_bank (
            .clk     (clk),
            .i_we    (w_we),
            .i_widx  (wr_addr[ADDR_BITS+3:4]),
            .i_wstrb (w_strb),
            .i_wdata (w_wdata),
            .i_ridx  (r_addr[ADDR_BITS+1:2]),
            .o_rdata (w_bank_rdata[g])
        );
    end

endmodule

// File: doc/cache_mem_responder.md
CACHE_MEM_RESPONDER -- requirements
Module: cache_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 12, line-index width (memory = 2^ADDR_BITS lines of 16 bytes).
REQ-002 SHALL have parameter RD_LAT, default 2, cycles from read accept to first beat; legal range 1..15.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port rd_req  in  1  read request.
REQ-006 SHALL have port rd_type  in  3  000 byte, 001 half, 010 word, 100 cache line.
REQ-007 SHALL have port rd_addr  in  32  read byte address.
REQ-008 SHALL have port rd_rdy  out  1  read request accepted when rd_req && rd_rdy.
REQ-009 SHALL have port ret_valid  out  1  read data beat valid.
REQ-010 SHALL have port ret_last  out  1  final beat of current read.
REQ-011 SHALL have port ret_data  out  32  read beat data.
REQ-012 SHALL have port wr_req  in  1  write request.
REQ-013 SHALL have port wr_type  in  3  encoding as rd_type.
REQ-014 SHALL have port wr_addr  in  32  write byte address.
REQ-015 SHALL have port wr_wstrb  in  4  byte enables, non-line writes only.
REQ-016 SHALL have port wr_data  in  128  line data; word n at bits [32n+31:32n].
REQ-017 SHALL have port wr_rdy  out  1  write accepted when wr_req && wr_rdy.

Function
REQ-018 SHALL implement states IDLE, WAIT, BURST; rd_rdy = wr_rdy = (state==IDLE && !reset).
REQ-019 Read accept (IDLE, rd_req) SHALL latch addr/type, load latency counter, go to WAIT; first ret_valid exactly RD_LAT cycles after accept edge.
REQ-020 WAIT SHALL decrement counter; at terminal count enter BURST.
REQ-021 Line read SHALL return 4 beats, words 0..3 of line rd_addr[ADDR_BITS+3:4], one per cycle, ret_last with beat 3; then IDLE.
REQ-022 Byte/half/word read SHALL return 1 beat: full aligned word at rd_addr[ADDR_BITS+3:2], ret_last=1; then IDLE.
REQ-023 Undefined type codes SHALL be treated as word.
REQ-024 Address bits above ADDR_BITS+3 SHALL be ignored (aliasing); bits [1:0] ignored.
REQ-025 Line write SHALL store all 16 bytes of wr_data at the accept edge, wr_wstrb ignored; non-line write SHALL store only wr_wstrb-enabled bytes of wr_data[31:0] to word wr_addr[ADDR_BITS+3:2].
REQ-026 Write SHALL complete in the accept cycle; no state change, no response.
REQ-027 Simultaneous rd_req and wr_req in IDLE SHALL both be accepted; read beats SHALL observe the written data.
REQ-028 Memory SHALL be read at beat time, not at accept.
REQ-029 ret_valid low SHALL force ret_data=0 and ret_last=0.
REQ-030 No request accepted outside IDLE; held requests are accepted on return to IDLE.

Reset
REQ-031 Reset SHALL force IDLE, counters 0, ret_valid=ret_last=0, ret_data=0, rd_rdy=wr_rdy=0 while asserted.
REQ-032 Reset mid-WAIT/BURST SHALL abort: no further beats; ret_valid low the cycle after reset is sampled.
REQ-033 Memory contents SHALL NOT be cleared by reset and are undefined after power-up.

Configuration
REQ-034 Macro CMEM_BEAT_GAP_EN: when defined, BURST SHALL insert one cycle with ret_valid=0 between consecutive beats (line read spans 7 cycles); when undefined, beats are back-to-back (4 cycles).
REQ-035 Single-beat reads and latency SHALL be unaffected by CMEM_BEAT_GAP_EN.

Structure
REQ-036 Package cmem_pkg SHALL hold type codes (T_BYTE, T_HALF, T_WORD, T_LINE), state encoding, and line/word width constants.
REQ-037 Storage SHALL be sub-module cmem_bank, instantiated 4 times (one per word of a line): 32-bit words, byte-strobed synchronous write, combinational read, indexed by line.
REQ-038 Line write SHALL enable all 4 banks; word write SHALL enable only bank addr[3:2].

Verification
REQ-039 Line write 0x1000 data {0x33333333,0x22222222,0x11111111,0x00000000}, then line read 0x1000 -> beats 0x0,0x11111111,0x22222222,0x33333333, ret_last on 4th, first beat RD_LAT cycles after accept.
REQ-040 Word write 0x1008 strb 4'b0011 data 0xAABBCCDD over 0x22222222, word read 0x100A -> single beat 0x2222CCDD, ret_last=1.
REQ-041 Same-cycle line write and line read to 0x2000 -> rd_rdy/wr_rdy both taken, read beats equal written words.
REQ-042 Reset asserted on 2nd beat of a line read -> ret_valid=0 next cycle, no ret_last, next read accepted normally.
REQ-043 CMEM_BEAT_GAP_EN defined, line read -> ret_valid pattern 1010101, ret_last on 7th burst cycle.
REQ-044 rd_req held during BURST -> rd_rdy=0 until IDLE, second read accepted the cycle after ret_last.
